// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states, indexing modes, PC word alignment.
package bp_pkg;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    localparam int unsigned MODE_BIMODAL = 0;
    localparam int unsigned MODE_GSHARE  = 1;

    localparam int unsigned PC_WORD_LSB = 2;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next_cnt_c
);

    always_comb begin
        next_cnt_c = cnt;
        case (cnt)
            CNT_SNT: next_cnt_c = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: next_cnt_c = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  next_cnt_c = taken ? CNT_ST  : CNT_WNT;
            default: next_cnt_c = taken ? CNT_ST  : CNT_WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor_gshare_param.sv
// BTB + PHT next-PC predictor: combinational prediction at IF, synchronous resolution updates from EX.
module branch_predictor_gshare_param
    import bp_pkg::*;
#(
    parameter int unsigned BTB_IDX_BITS = 5,
    parameter int unsigned PHT_IDX_BITS = 6,
    parameter int unsigned HIST_BITS    = 6,
    parameter int unsigned MODE         = MODE_GSHARE,
    parameter logic [1:0]  INIT_CNT     = CNT_WT
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             current_pc,
    output logic [31:0]             predicted_next_pc,
    output logic                    predicted_taken,
    output logic [PHT_IDX_BITS-1:0] predict_pht_idx,
    input  logic                    update_valid,
    input  logic                    update_is_cond,
    input  logic [31:0]             update_pc,
    input  logic [31:0]             update_target,
    input  logic                    update_taken,
    input  logic [PHT_IDX_BITS-1:0] update_pht_idx,
    input  logic                    update_mispredict,
    output logic [31:0]             stat_updates,
    output logic [31:0]             stat_mispredicts
);

    localparam int unsigned BTB_N   = 1 << BTB_IDX_BITS;
    localparam int unsigned PHT_N   = 1 << PHT_IDX_BITS;
    localparam int unsigned TAG_LSB = BTB_IDX_BITS + PC_WORD_LSB;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;

    logic [31:0]             btb_target [BTB_N];
    logic [TAG_W-1:0]        btb_tag    [BTB_N];
    logic [BTB_N-1:0]        btb_valid;
    logic [BTB_N-1:0]        btb_uncond;
    logic [1:0]              pht        [PHT_N];
    logic [HIST_BITS-1:0]    ghr;
    logic [HIST_BITS-1:0]    ghr_next;

    logic [BTB_IDX_BITS-1:0] pred_btb_idx;
    logic [BTB_IDX_BITS-1:0] upd_btb_idx;
    logic [TAG_W-1:0]        pred_tag;
    logic [TAG_W-1:0]        upd_tag;
    logic [PHT_IDX_BITS-1:0] pred_pc_bits;
    logic [PHT_IDX_BITS-1:0] hist_ext;
    logic                    hit;
    logic [1:0]              upd_cnt_next;
    logic [1:0]              unused_upd_pc_lsb;

    assign pred_btb_idx      = current_pc[PC_WORD_LSB +: BTB_IDX_BITS];
    assign pred_tag          = current_pc[31:TAG_LSB];
    assign upd_btb_idx       = update_pc[PC_WORD_LSB +: BTB_IDX_BITS];
    assign upd_tag           = update_pc[31:TAG_LSB];
    assign unused_upd_pc_lsb = update_pc[PC_WORD_LSB-1:0];

    // Prediction reads only current state, so a same-cycle update is seen one cycle later.
    assign pred_pc_bits    = current_pc[PC_WORD_LSB +: PHT_IDX_BITS];
    assign hist_ext        = PHT_IDX_BITS'(ghr);
    assign predict_pht_idx = (MODE == MODE_BIMODAL) ? pred_pc_bits : (pred_pc_bits ^ hist_ext);

    assign hit               = btb_valid[pred_btb_idx] && (btb_tag[pred_btb_idx] == pred_tag);
    assign predicted_taken   = hit && (btb_uncond[pred_btb_idx] || pht[predict_pht_idx][1]);
    assign predicted_next_pc = predicted_taken ? btb_target[pred_btb_idx] : (current_pc + 32'd4);

    bp_sat_counter2 u_sat_counter (
        .cnt        (pht[update_pht_idx]),
        .taken      (update_taken),
        .next_cnt_c (upd_cnt_next)
    );

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign ghr_next = update_taken;
        end else begin : g_hist_shift
            assign ghr_next = {ghr[HIST_BITS-2:0], update_taken};
        end
    endgenerate

    // Reset wins over a same-cycle update; JAL updates leave PHT and history alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid        <= '0;
            btb_uncond       <= '0;
            ghr              <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_target[i] <= '0;
                btb_tag[i]    <= '0;
            end
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= INIT_CNT;
            end
        end else if (update_valid) begin
            btb_valid[upd_btb_idx]  <= 1'b1;
            btb_uncond[upd_btb_idx] <= !update_is_cond;
            btb_target[upd_btb_idx] <= update_target;
            btb_tag[upd_btb_idx]    <= upd_tag;
            if (update_is_cond) begin
                pht[update_pht_idx] <= upd_cnt_next;
                ghr                 <= ghr_next;
            end
            if (stat_updates != '1) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (update_mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare_param.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic against a reference model.
module tb_branch_predictor_gshare_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] current_pc;
    logic [31:0] predicted_next_pc;
    logic        predicted_taken;
    logic [5:0]  predict_pht_idx;
    logic        update_valid;
    logic        update_is_cond;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [5:0]  update_pht_idx;
    logic        update_mispredict;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    logic [31:0] b_next_pc;
    logic        b_taken;
    logic [5:0]  b_pht_idx;
    logic [31:0] b_stat_updates;
    logic [31:0] b_stat_mispredicts;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare_param dut (
        .clk(clk), .reset(reset), .current_pc(current_pc),
        .predicted_next_pc(predicted_next_pc), .predicted_taken(predicted_taken),
        .predict_pht_idx(predict_pht_idx), .update_valid(update_valid),
        .update_is_cond(update_is_cond), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken),
        .update_pht_idx(update_pht_idx), .update_mispredict(update_mispredict),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor_gshare_param #(.MODE(0)) dut_bimodal (
        .clk(clk), .reset(reset), .current_pc(current_pc),
        .predicted_next_pc(b_next_pc), .predicted_taken(b_taken),
        .predict_pht_idx(b_pht_idx), .update_valid(update_valid),
        .update_is_cond(update_is_cond), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken),
        .update_pht_idx(update_pht_idx), .update_mispredict(update_mispredict),
        .stat_updates(b_stat_updates), .stat_mispredicts(b_stat_mispredicts)
    );

    // Reference model: 32-entry BTB, 64-entry PHT, 6-bit history, gshare indexing.
    bit          m_valid  [32];
    bit          m_uncond [32];
    logic [31:0] m_tgt    [32];
    logic [31:0] m_tag    [32];
    int          m_pht    [64];
    int          m_ghr;
    longint      m_upd;
    longint      m_mis;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_uncond[i] = 1'b0; m_tgt[i] = '0; m_tag[i] = '0;
        end
        for (int i = 0; i < 64; i++) m_pht[i] = 2;
        m_ghr = 0; m_upd = 0; m_mis = 0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output bit t,
                                      output logic [31:0] nxt, output int idx);
        int bi;
        bit hit;
        bi  = int'((pc >> 2) & 32'h1F);
        idx = int'((pc >> 2) & 32'h3F) ^ m_ghr;
        hit = m_valid[bi] && (m_tag[bi] == (pc >> 7));
        t   = hit && (m_uncond[bi] || (m_pht[idx] >= 2));
        nxt = t ? m_tgt[bi] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic [31:0] tgt,
                                     input bit cond, input bit tk, input int idx, input bit mis);
        int bi;
        bi = int'((pc >> 2) & 32'h1F);
        m_valid[bi] = 1'b1; m_uncond[bi] = !cond; m_tgt[bi] = tgt; m_tag[bi] = pc >> 7;
        if (cond) begin
            if (tk) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
            else    m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
            m_ghr = (m_ghr * 2 + int'(tk)) % 64;
        end
        if (m_upd < 64'hFFFF_FFFF) m_upd++;
        if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        bit t; logic [31:0] nxt; int idx;
        m_predict(current_pc, t, nxt, idx);
        chk({tag, "_taken"}, 32'(predicted_taken), 32'(t));
        chk({tag, "_next"}, predicted_next_pc, nxt);
        chk({tag, "_idx"}, 32'(predict_pht_idx), 32'(idx));
        chk({tag, "_supd"}, stat_updates, 32'(m_upd));
        chk({tag, "_smis"}, stat_mispredicts, 32'(m_mis));
        chk({tag, "_bidx"}, 32'(b_pht_idx), (current_pc >> 2) & 32'h3F);
    endtask

    // Commit the currently driven inputs at the next edge, in both DUT and model.
    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else if (update_valid)
            m_update(update_pc, update_target, update_is_cond, update_taken,
                     int'(update_pht_idx), update_mispredict);
        #1;
    endtask

    task automatic set_upd(input bit v, input bit cond, input logic [31:0] pc,
                           input logic [31:0] tgt, input bit tk, input logic [5:0] idx, input bit mis);
        update_valid = v; update_is_cond = cond; update_pc = pc; update_target = tgt;
        update_taken = tk; update_pht_idx = idx; update_mispredict = mis;
    endtask

    task automatic idle();
        set_upd(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) p = p | 32'h0000_0100;
        if ($urandom_range(0, 7) == 0) p = p | 32'h8000_0000;
        return p;
    endfunction

    typedef struct {
        bit          upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [31:0] ppc;
        bit          et;
        logic [31:0] enext;
        logic [31:0] eidx;
    } vec_t;

    vec_t vecs [8];
    int   exp_idx [7] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h11, 32'h13, 32'h17};
    bit   exp_tk  [7] = '{0, 0, 0, 0, 1, 1, 1};
    bit   outcome [7] = '{0, 0, 0, 1, 1, 1, 1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] cap;

        // JAL updates (table) including same-cycle pre-update view, aliasing and ignored pc[1:0].
        vecs[0] = '{1'b1, 32'h100, 32'h200, 32'h100, 1'b0, 32'h104, 32'h00};
        vecs[1] = '{1'b0, 32'h0,   32'h0,   32'h100, 1'b1, 32'h200, 32'h00};
        vecs[2] = '{1'b0, 32'h0,   32'h0,   32'h040, 1'b0, 32'h044, 32'h10};
        vecs[3] = '{1'b1, 32'h040, 32'h300, 32'h040, 1'b0, 32'h044, 32'h10};
        vecs[4] = '{1'b1, 32'h0C0, 32'h400, 32'h040, 1'b1, 32'h300, 32'h10};
        vecs[5] = '{1'b0, 32'h0,   32'h0,   32'h040, 1'b0, 32'h044, 32'h10};
        vecs[6] = '{1'b0, 32'h0,   32'h0,   32'h0C0, 1'b1, 32'h400, 32'h30};
        vecs[7] = '{1'b0, 32'h0,   32'h0,   32'h102, 1'b1, 32'h200, 32'h00};

        reset = 1'b1; current_pc = '0; idle();
        tick(); tick();
        reset = 1'b0;

        current_pc = 32'h100; #1;
        chk("rst_taken", 32'(predicted_taken), 32'h0);
        chk("rst_next", predicted_next_pc, 32'h104);
        chk("rst_supd", stat_updates, 32'h0);
        chk("rst_smis", stat_mispredicts, 32'h0);

        for (int i = 0; i < 8; i++) begin
            set_upd(vecs[i].upd, 1'b0, vecs[i].upc, vecs[i].utgt, 1'b0, '0, 1'b0);
            current_pc = vecs[i].ppc; #1;
            chk($sformatf("vec%0d_taken", i), 32'(predicted_taken), 32'(vecs[i].et));
            chk($sformatf("vec%0d_next", i), predicted_next_pc, vecs[i].enext);
            chk($sformatf("vec%0d_idx", i), 32'(predict_pht_idx), vecs[i].eidx);
            chk_model($sformatf("vec%0d_m", i));
            tick();
        end
        idle(); #1;
        chk("jal_supd", stat_updates, 32'd3);

        // Conditional branch trained with its own captured prediction index.
        for (int i = 0; i < 7; i++) begin
            idle(); current_pc = 32'h40; #1;
            cap = predict_pht_idx;
            chk($sformatf("cond%0d_idx", i), 32'(cap), 32'(exp_idx[i]));
            chk($sformatf("cond%0d_taken", i), 32'(predicted_taken), 32'(exp_tk[i]));
            chk($sformatf("cond%0d_bidx", i), 32'(b_pht_idx), 32'h10);
            chk_model($sformatf("cond%0d_m", i));
            set_upd(1'b1, 1'b1, 32'h40, 32'h80, outcome[i], cap, 1'b0);
            tick();
        end
        idle(); #1;
        chk("cond_final_idx", 32'(predict_pht_idx), 32'h1F);
        chk("cond_final_taken", 32'(predicted_taken), 32'h1);
        chk("cond_final_next", predicted_next_pc, 32'h80);
        chk("bimodal_idx", 32'(b_pht_idx), 32'h10);

        // Stalled cycles must not change anything.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_upd(1'b0, 1'($urandom), rand_pc(), $urandom, 1'($urandom), 6'($urandom), 1'($urandom));
            current_pc = rand_pc(); #1;
            chk_model($sformatf("stall%0d", i));
            tick();
        end
        idle(); current_pc = 32'h100; #1;
        chk("stall_supd", stat_updates, 32'h0);
        chk("stall_taken", 32'(predicted_taken), 32'h0);
        set_upd(1'b1, 1'b1, 32'h200, 32'h280, 1'b1, 6'h05, 1'b1); tick();
        set_upd(1'b1, 1'b0, 32'h300, 32'h380, 1'b0, 6'h00, 1'b0); tick();
        idle(); #1;
        chk("stat_supd", stat_updates, 32'd2);
        chk("stat_smis", stat_mispredicts, 32'd1);

        // Reset coinciding with a valid update drops the update.
        set_upd(1'b1, 1'b0, 32'h100, 32'h500, 1'b0, 6'h00, 1'b1);
        reset = 1'b1; tick(); reset = 1'b0; idle();
        current_pc = 32'h100; #1;
        chk("rstupd_taken", 32'(predicted_taken), 32'h0);
        chk("rstupd_next", predicted_next_pc, 32'h104);
        chk("rstupd_supd", stat_updates, 32'h0);
        current_pc = 32'h200; #1;
        chk("rstupd_next2", predicted_next_pc, 32'h204);
        current_pc = 32'h300; #1;
        chk("rstupd_next3", predicted_next_pc, 32'h304);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_upd($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rand_pc(), $urandom,
                    1'($urandom), 6'($urandom), 1'($urandom));
            current_pc = rand_pc(); #1;
            chk_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare_param.md
Name: branch_predictor_gshare_param

Overview:
Parametrised next-generation global-history branch predictor for the pipelined RV32 CPU. It makes asynchronous next-PC predictions at IF and takes synchronous resolution updates from EX. It adds the following over the current predictor:
- selectable bimodal/gshare mode
- word-aligned indexing
- a carried PHT index, so the counter updated is exactly the counter that made the prediction
- unconditional-jump tagging
- saturating performance counters

Parameters:
BTB_IDX_BITS, 5, log2 of BTB entries (1..10)
PHT_IDX_BITS, 6, log2 of PHT entries (1..12)
HIST_BITS, 6, global history length; must satisfy 1 <= HIST_BITS <= PHT_IDX_BITS
MODE, 1, 0 = bimodal (PHT indexed by PC only), 1 = gshare (PC xor history)
INIT_CNT, 2'b10, PHT reset value (weakly taken)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
current_pc  in  32  IF-stage PC to predict
predicted_next_pc  out  32  predicted fetch address
predicted_taken  out  1  prediction is taken
predict_pht_idx  out  PHT_IDX_BITS  PHT index used for this prediction; pipelined alongside the instruction
update_valid  in  1  resolved branch/JAL this cycle (0 during stall/bubble)
update_is_cond  in  1  1 = conditional branch, 0 = JAL
update_pc  in  32  PC of resolved instruction
update_target  in  32  resolved target address
update_taken  in  1  actual outcome
update_pht_idx  in  PHT_IDX_BITS  predict_pht_idx captured at prediction time
update_mispredict  in  1  EX detected a mispredict for this instruction
stat_updates  out  32  count of accepted updates
stat_mispredicts  out  32  count of accepted updates with update_mispredict=1

Behaviour:
- Storage per BTB entry: target[31:0], tag[31-BTB_IDX_BITS-2:0], valid, uncond.
- BTB index = pc[BTB_IDX_BITS+1:2]; tag = pc[31:BTB_IDX_BITS+2]. Bits pc[1:0] are ignored.
- PHT index:
  - MODE=1: pc[PHT_IDX_BITS+1:2] xor zero-extended ghr[HIST_BITS-1:0]
  - MODE=0: pc[PHT_IDX_BITS+1:2]
  - Output on predict_pht_idx.
- Prediction is purely combinational from current state.
  - hit = valid && tag match.
  - taken = hit && (uncond || PHT[idx][1]).
  - predicted_next_pc = taken ? target : current_pc+4, with 32-bit wrap.
- Update happens at posedge clk when update_valid && !reset:
  - BTB entry at update_pc's index is written with tag, target and valid=1; uncond = !update_is_cond.
  - Conditional only: PHT[update_pht_idx] moves as a saturating counter (taken: +1 capped at 3; not-taken: -1 floored at 0).
  - Conditional only: ghr <= {ghr[HIST_BITS-2:0], update_taken}. When HIST_BITS=1, ghr <= update_taken.
  - JAL: PHT and ghr are unchanged.
  - stat_updates increments; stat_mispredicts increments if update_mispredict. Both saturate at 32'hFFFF_FFFF (no wrap).
- update_valid=0 leaves all state unchanged, so a stalled pipeline needs no extra handling.
- Simultaneous update and prediction on the same entry: the prediction uses pre-update state. The new state is visible the next cycle.
- Tag conflict on update: unconditional overwrite, no replacement policy.
- Reset (synchronous, wins over update):
  - all valid=0, uncond=0, targets=0, tags=0
  - PHT=INIT_CNT, ghr=0, stats=0
- Output behaviour after reset: predicted_taken=0 and predicted_next_pc=current_pc+4 for any PC. Reset mid-stream discards any same-cycle update.
- update_pht_idx is trusted as given; the block does not recompute it.

Decomposition:
- Shared package bp_pkg: counter encodings (SNT=0, WNT=1, WT=2, ST=3), MODE_BIMODAL/MODE_GSHARE constants, PC_WORD_LSB=2.
- One sub-module: bp_sat_counter2, a combinational 2-bit next-state function reused from the counter logic. BTB and PHT arrays stay inline.

Test Plan:
1. Reset with defaults, then current_pc=0x100 -> predicted_taken=0, predicted_next_pc=0x104, stats=0.
2. JAL update pc=0x100, target=0x200, then predict 0x100 -> taken=1, next_pc=0x200. ghr stays 0 and stat_updates=1.
3. MODE=1: conditional branch pc=0x40, target=0x80, resolved not-taken 3 times, each time feeding back the predict_pht_idx captured from the preceding predict. Expected ghr=0 throughout, idx stays 0x10, and the counter goes 2->1->0->0 with predicted_taken dropping to 0 after the first update. Then 4 taken outcomes. Expected: each outcome updates the counter at the index captured at its own predict (0x10^ghr). Final ghr=0x0F.
4. Aliasing: update pc=0x40, then pc=0x40+(4<<BTB_IDX_BITS)=0xC0 -> predict 0x40 misses (next_pc=0x44), predict 0xC0 hits.
5. update_valid=0 for 10 cycles with other inputs toggling -> no state or stat change. Then 2 updates with update_mispredict=1,0 -> stat_updates=2, stat_mispredicts=1.
6. Assert reset in the same cycle as a valid update -> the update is dropped and all entries are invalid. Also for MODE=0: different ghr values give an identical predict_pht_idx for the same PC.
